// File: rtl/lm_sm_sequencer.sv
// Memory-stage LM/SM sequencer: moves one register per cycle between data_memory and the
// register file, walking reg_mask from R0 upward. Optional feature macro: LMSM_BASE_WB_EN.
module lm_sm_sequencer #(
  parameter int ADDR_W = 16,
  parameter int NREG   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              is_store,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [NREG-1:0]   reg_mask,
  input  logic [2:0]        base_reg,
  output logic [ADDR_W-1:0] mem_access_addr,
  output logic [ADDR_W-1:0] mem_write_data,
  output logic              mem_write_en,
  output logic              mem_read,
  input  logic [ADDR_W-1:0] mem_read_data,
  output logic [2:0]        rf_rd_addr,
  input  logic [ADDR_W-1:0] rf_rd_data,
  output logic              rf_wr_en,
  output logic [2:0]        rf_wr_addr,
  output logic [ADDR_W-1:0] rf_wr_data,
  output logic              stall,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [NREG-1:0]   rem_mask_q, rem_mask_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic              is_store_q, is_store_d;
  logic              busy_q, done_q;

  logic [2:0]        idx;
  logic [NREG-1:0]   idx_onehot;

  // Lowest set bit of the remaining mask selects the register served this cycle.
  assign idx_onehot = rem_mask_q & (~rem_mask_q + NREG'(1));

  always_comb begin
    idx = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (rem_mask_q[i]) idx = i[2:0];
    end
  end

  always_comb begin
    state_d    = state_q;
    rem_mask_d = rem_mask_q;
    cur_addr_d = cur_addr_q;
    is_store_d = is_store_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          is_store_d = is_store;
          cur_addr_d = base_addr;
          rem_mask_d = reg_mask;
          state_d    = (reg_mask == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        rem_mask_d = rem_mask_q & ~idx_onehot;
        cur_addr_d = cur_addr_q + ADDR_W'(1);
        if (rem_mask_d == '0) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rem_mask_q <= '0;
      cur_addr_q <= '0;
      is_store_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_mask_q <= rem_mask_d;
      cur_addr_q <= cur_addr_d;
      is_store_q <= is_store_d;
      busy_q     <= (state_d != IDLE);
      done_q     <= (state_d == DONE);
    end
  end

  assign busy = busy_q;
  assign done = done_q;

  // Stall in IDLE follows start directly so the instruction is held during its accept cycle;
  // it is gated by rst_n so every output reads 0 while reset is asserted.
  always_comb begin
    mem_access_addr = '0;
    mem_write_data  = '0;
    mem_write_en    = 1'b0;
    mem_read        = 1'b0;
    rf_rd_addr      = '0;
    rf_wr_en        = 1'b0;
    rf_wr_addr      = '0;
    rf_wr_data      = '0;
    stall           = 1'b0;
    unique case (state_q)
      IDLE: stall = start & rst_n;
      RUN: begin
        stall           = 1'b1;
        mem_access_addr = cur_addr_q;
        if (is_store_q) begin
          rf_rd_addr     = idx;
          mem_write_data = rf_rd_data;
          mem_write_en   = 1'b1;
        end else begin
          mem_read   = 1'b1;
          rf_wr_en   = 1'b1;
          rf_wr_addr = idx;
          rf_wr_data = mem_read_data;
        end
      end
      DONE: begin
        stall = 1'b1;
`ifdef LMSM_BASE_WB_EN
        rf_wr_en   = 1'b1;
        rf_wr_addr = base_reg;
        rf_wr_data = cur_addr_q;
`endif
      end
      default: stall = 1'b0;
    endcase
  end

`ifndef LMSM_BASE_WB_EN
  logic [2:0] unused_base_reg;
  assign unused_base_reg = base_reg;
`endif

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Self-checking bench for lm_sm_sequencer: table of LM/SM operations plus a scoreboard of
// expected memory/register-file transfers, and a hand-written mid-RUN reset sequence.
module tb_lm_sm_sequencer;

  typedef enum int {K_LM, K_SM, K_WB} kind_e;

  typedef struct {
    kind_e       kind;
    logic [15:0] addr;
    logic [2:0]  regIdx;
    logic [15:0] data;
  } sbEntry_t;

  typedef struct {
    logic        isStore;
    logic [15:0] base;
    logic [7:0]  mask;
    logic [2:0]  baseReg;
    int          expLat;
    int          pulseAt;
  } vec_t;

`ifdef LMSM_BASE_WB_EN
  localparam int WB = 1;
`else
  localparam int WB = 0;
`endif

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        isStore;
  logic [15:0] baseAddr;
  logic [7:0]  regMask;
  logic [2:0]  baseReg;
  logic [15:0] memAccessAddr;
  logic [15:0] memWriteData;
  logic        memWriteEn;
  logic        memRead;
  logic [15:0] memReadData;
  logic [2:0]  rfRdAddr;
  logic [15:0] rfRdData;
  logic        rfWrEn;
  logic [2:0]  rfWrAddr;
  logic [15:0] rfWrData;
  logic        stall;
  logic        busy;
  logic        done;

  logic [15:0] mem [0:65535];
  logic [15:0] rf [0:7];
  logic [15:0] rfSeed [0:7];
  sbEntry_t    sb[$];
  vec_t        vecs[8];

  int vecCount = 0;
  int missCount = 0;

  lm_sm_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .is_store       (isStore),
    .base_addr      (baseAddr),
    .reg_mask       (regMask),
    .base_reg       (baseReg),
    .mem_access_addr(memAccessAddr),
    .mem_write_data (memWriteData),
    .mem_write_en   (memWriteEn),
    .mem_read       (memRead),
    .mem_read_data  (memReadData),
    .rf_rd_addr     (rfRdAddr),
    .rf_rd_data     (rfRdData),
    .rf_wr_en       (rfWrEn),
    .rf_wr_addr     (rfWrAddr),
    .rf_wr_data     (rfWrData),
    .stall          (stall),
    .busy           (busy),
    .done           (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign memReadData = mem[memAccessAddr];
  assign rfRdData    = rf[rfRdAddr];

  always @(posedge clk) begin
    if (memWriteEn) mem[memAccessAddr] <= memWriteData;
    if (rfWrEn) rf[rfWrAddr] <= rfWrData;
  end

  function automatic logic [15:0] memSeed(input logic [15:0] a);
    if (a == 16'h0010) return 16'hAAAA;
    if (a == 16'h0011) return 16'hBBBB;
    return a ^ 16'h5A5A;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every enable pulse seen on the DUT must match the oldest outstanding expected transfer.
  always @(negedge clk) begin
    sbEntry_t e;
    if (rst_n && (memWriteEn || rfWrEn)) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_access", {memWriteEn, rfWrEn}, 32'd0);
      end else begin
        e = sb.pop_front();
        case (e.kind)
          K_LM: begin
            checkOutput("lm_enables", {rfWrEn, memRead, memWriteEn}, 3'b110);
            checkOutput("lm_addr", memAccessAddr, e.addr);
            checkOutput("lm_reg", rfWrAddr, e.regIdx);
            checkOutput("lm_data", rfWrData, e.data);
          end
          K_SM: begin
            checkOutput("sm_enables", {rfWrEn, memRead, memWriteEn}, 3'b001);
            checkOutput("sm_addr", memAccessAddr, e.addr);
            checkOutput("sm_reg", rfRdAddr, e.regIdx);
            checkOutput("sm_data", memWriteData, e.data);
          end
          default: begin
            checkOutput("wb_enables", {rfWrEn, memRead, memWriteEn, done}, 4'b1001);
            checkOutput("wb_reg", rfWrAddr, e.regIdx);
            checkOutput("wb_data", rfWrData, e.data);
            checkOutput("wb_memaddr", memAccessAddr, 16'h0);
          end
        endcase
      end
    end
  end

  task automatic pushExpect(input vec_t v);
    logic [15:0] cur;
    sbEntry_t e;
    cur = v.base;
    for (int i = 0; i < 8; i++) begin
      if (v.mask[i]) begin
        e.kind   = v.isStore ? K_SM : K_LM;
        e.addr   = cur;
        e.regIdx = i[2:0];
        e.data   = v.isStore ? rfSeed[i] : memSeed(cur);
        sb.push_back(e);
        cur = cur + 16'd1;
      end
    end
    if (WB != 0) begin
      e.kind   = K_WB;
      e.addr   = 16'h0;
      e.regIdx = v.baseReg;
      e.data   = cur;
      sb.push_back(e);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    int  cyc;
    bit  seen;
    @(negedge clk);
    for (int i = 0; i < 8; i++) rf[i] = rfSeed[i];
    pushExpect(v);
    isStore  = v.isStore;
    baseAddr = v.base;
    regMask  = v.mask;
    baseReg  = v.baseReg;
    start    = 1'b1;
    #1;
    checkOutput("accept_stall", stall, 1'b1);
    checkOutput("accept_busy", busy, 1'b0);
    @(posedge clk);
    #1;
    start    = 1'b0;
    isStore  = ~v.isStore;
    baseAddr = ~v.base;
    regMask  = ~v.mask;
    baseReg  = ~v.baseReg;
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (v.pulseAt != 0 && cyc == v.pulseAt) begin
        start   = 1'b1;
        regMask = 8'hFF;
      end else if (v.pulseAt != 0 && cyc == v.pulseAt + 1) begin
        start = 1'b0;
      end
      checkOutput("busy_stall", {busy, stall}, 2'b11);
      if (done) begin
        seen = 1'b1;
        checkOutput("latency", cyc, v.expLat);
      end
    end
    if (!seen) checkOutput("done_timeout", 32'd0, 32'd1);
    @(negedge clk);
    checkOutput("idle_flags", {busy, stall, done, memRead, memWriteEn, rfWrEn}, 6'b0);
    checkOutput("idle_addr", memAccessAddr, 16'h0);
    checkOutput("sb_drained", sb.size(), 32'd0);
    sb.delete();
  endtask

  task automatic midRunReset();
    vec_t v;
    v = '{1'b0, 16'h2000, 8'hFF, 3'd5, 9, 0};
    @(negedge clk);
    for (int i = 0; i < 8; i++) rf[i] = rfSeed[i];
    pushExpect(v);
    isStore  = v.isStore;
    baseAddr = v.base;
    regMask  = v.mask;
    baseReg  = v.baseReg;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("abort_flags", {busy, stall, done, memRead, memWriteEn, rfWrEn}, 6'b0);
    checkOutput("abort_bus", {memAccessAddr, rfWrData}, 32'h0);
    checkOutput("abort_remaining", sb.size(), 32'(5 + WB));
    sb.delete();
    for (int i = 0; i < 3; i++) checkOutput("abort_committed", rf[i], memSeed(16'h2000 + 16'(i)));
    checkOutput("abort_r3_kept", rf[3], rfSeed[3]);
    checkOutput("abort_r7_kept", rf[7], rfSeed[7]);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus('{1'b1, 16'h3000, 8'h11, 3'd2, 3, 0});
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b1;
    isStore  = 1'b1;
    baseAddr = 16'hBEEF;
    regMask  = 8'hFF;
    baseReg  = 3'd0;
    for (int a = 0; a < 65536; a++) mem[a] = memSeed(a[15:0]);
    rfSeed[0] = 16'h0F00; rfSeed[1] = 16'h1234; rfSeed[2] = 16'h2222; rfSeed[3] = 16'h3333;
    rfSeed[4] = 16'h4444; rfSeed[5] = 16'h5555; rfSeed[6] = 16'h6666; rfSeed[7] = 16'h5678;
    for (int i = 0; i < 8; i++) rf[i] = rfSeed[i];

    vecs[0] = '{1'b0, 16'h0010, 8'h05, 3'd0, 3, 0};
    vecs[1] = '{1'b1, 16'h0020, 8'h82, 3'd1, 3, 0};
    vecs[2] = '{1'b0, 16'h0030, 8'h00, 3'd3, 1, 0};
    vecs[3] = '{1'b1, 16'hFFFF, 8'h03, 3'd4, 3, 0};
    vecs[4] = '{1'b0, 16'h1234, 8'hFF, 3'd7, 9, 0};
    vecs[5] = '{1'b1, 16'hFFFE, 8'hF0, 3'd2, 5, 0};
    vecs[6] = '{1'b0, 16'h4000, 8'h81, 3'd5, 3, 0};
    vecs[7] = '{1'b0, 16'h0100, 8'h0F, 3'd6, 5, 2};

    #2;
    checkOutput("reset_flags", {busy, stall, done, memRead, memWriteEn, rfWrEn}, 6'b0);
    checkOutput("reset_addr", memAccessAddr, 16'h0);
    checkOutput("reset_wdata", memWriteData, 16'h0);
    checkOutput("reset_rf", {rfWrAddr, rfRdAddr, rfWrData}, 32'h0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_idle", {busy, stall, done}, 3'b0);

    for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);
    midRunReset();

    $display("[TB] == %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
